// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell with a registered borrow; parallel operands and results.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             borrow_q;
  logic             a_msb, b_msb;
  logic [CW-1:0]    count;

  logic x_c, y_c, d_c, borrow_c, last_c;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    x_c      = a_sh[0];
    y_c      = b_sh[0];
    d_c      = x_c ^ y_c ^ borrow_q;
    borrow_c = (~x_c & y_c) | (~(x_c ^ y_c) & borrow_q);
    last_c   = (count == CW'(WIDTH - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      borrow_q <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            borrow_q <= bin;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            count    <= '0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          res_sh   <= {d_c, res_sh[WIDTH-1:1]};
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          borrow_q <= borrow_c;
          count    <= count + CW'(1);
        end
        S_FIN: begin
          diff <= res_sh;
          bout <= borrow_q;
          ovf  <= (a_msb != b_msb) & (res_sh[WIDTH-1] != a_msb);
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=3.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start3, bin3, busy3, done3, bout3, ovf3;
  logic [2:0] a3, b3, diff3;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation: latency, busy length, result stability during RUN, results
  task automatic do8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic bi, input logic [7:0] ed, input logic eb, input logic eo);
    int lat, bcnt;
    logic [7:0] held;
    logic changed;
    @(negedge clk);
    a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~av; b8 = ~bv; bin8 = ~bi;
    lat = 0; bcnt = busy8 ? 1 : 0; held = diff8; changed = 1'b0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
      if (!done8 && diff8 !== held) changed = 1'b1;
    end
    check({tag, "_lat"}, 32'(lat), 32'd9);
    check({tag, "_busy"}, 32'(bcnt), 32'd9);
    check({tag, "_hold"}, 32'(changed), 32'd0);
    check({tag, "_diff"}, 32'(diff8), 32'(ed));
    check({tag, "_bout"}, 32'(bout8), 32'(eb));
    check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
  endtask

  task automatic do3(input logic [2:0] av, input logic [2:0] bv, input logic bi);
    int lat;
    logic [2:0] ed;
    logic eb, eo;
    ed = 3'(int'(av) - int'(bv) - int'(bi));
    eb = (int'(av) < int'(bv) + int'(bi));
    eo = (av[2] != bv[2]) && (ed[2] != av[2]);
    @(negedge clk);
    a3 = av; b3 = bv; bin3 = bi; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w3_lat", 32'(lat), 32'd4);
    check("w3_diff", 32'(diff3), 32'(ed));
    check("w3_bout", 32'(bout3), 32'(eb));
    check("w3_ovf", 32'(ovf3), 32'(eo));
  endtask

  initial begin
    logic [7:0] ra, rb, rd;
    logic       rbi, reb, reo;
    int         pulses;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
    #12;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_bout", 32'(bout8), 32'd0);
    check("rst_ovf", 32'(ovf8), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do8("t1", 8'h5A, 8'h25, 1'b0, 8'h35, 1'b0, 1'b0);

    do8("t2", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("t2_idle_diff", 32'(diff8), 32'hFF);
      check("t2_idle_done", 32'(done8), 32'd0);
    end

    do8("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do8("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    do8("t4a", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    do8("t4b", 8'h33, 8'h33, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start held high with operands changing every cycle; accepted at E0 and E10
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a8 = 8'(k * 17 + 3); b8 = 8'(k * 5 + 1); bin8 = (k % 3 == 1); start8 = 1'b1;
      @(posedge clk); #1;
      check("t5_done", 32'(done8), 32'((k == 9) || (k == 19)));
      if (k == 9) begin
        check("t5_diff0", 32'(diff8), 32'h02);
        check("t5_bout0", 32'(bout8), 32'd0);
        check("t5_ovf0", 32'(ovf8), 32'd0);
      end
      if (k == 19) begin
        check("t5_diff1", 32'(diff8), 32'h79);
        check("t5_bout1", 32'(bout8), 32'd0);
        check("t5_ovf1", 32'(ovf8), 32'd1);
      end
    end
    @(negedge clk); start8 = 1'b0;

    // reset during RUN clears outputs at once and suppresses done
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h25; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy8), 32'd0);
    check("t6_done", 32'(done8), 32'd0);
    check("t6_diff", 32'(diff8), 32'd0);
    check("t6_bout", 32'(bout8), 32'd0);
    check("t6_ovf", 32'(ovf8), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) pulses++;
    end
    check("t6_no_done", 32'(pulses), 32'd0);
    do8("t6_next", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      rd = 8'(int'(ra) - int'(rb) - int'(rbi));
      reb = (int'(ra) < int'(rb) + int'(rbi));
      reo = (ra[7] != rb[7]) && (rd[7] != ra[7]);
      do8("rnd8", ra, rb, rbi, rd, reb, reo);
    end

    for (int i = 0; i < 1000; i++)
      do3(3'($urandom), 3'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
